writeback_unit: RTL
===================

Name: writeback_unit

Overview:
- Final pipeline stage of the CPU. Sits directly upstream of the register file and drives its single write port (wa/wen/wd).
- Retires ALU results from the MEM stage.
- Holds the pipeline while one outstanding data-bus load returns, then sign/zero-extends and aligns the load data before writing it.
- Also maintains a retired-instruction counter.

Parameters:
- TIMEOUT_CYCLES, 255, cycles waited for dbus_rvalid before a load is abandoned; used only with WB_LOAD_TIMEOUT_EN; range 1..65535.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low
- mem_valid  input  1  MEM stage presents an instruction this cycle
- mem_regwrite  input  1  instruction writes rd
- mem_is_load  input  1  instruction is a load; result comes from dbus
- mem_rd  input  5  destination register
- mem_funct3  input  3  load size/sign (RV32I encoding)
- mem_addr_lo  input  2  load address bits [1:0]
- mem_alu_result  input  32  result for non-load instructions
- dbus_rvalid  input  1  load data valid, 1-cycle pulse
- dbus_rdata  input  32  raw little-endian load word
- rf_wen  output  1  register file write enable
- rf_wa  output  5  register file write address
- rf_wd  output  32  register file write data
- wb_stall  output  1  MEM stage must hold its instruction
- load_busy_rd  output  5  rd of the pending load; 0 when idle
- load_fault  output  1  1-cycle pulse on load timeout (feature only)
- retire_cnt  output  32  instructions retired, wraps

Behaviour:
- Reset (async, reset==0): state=IDLE; rf_wen=0, rf_wa=0, rf_wd=0, load_busy_rd=0, load_fault=0, retire_cnt=0. Reset mid-load abandons the load; a later dbus_rvalid while IDLE is ignored.
- States: IDLE, WAIT_LOAD.
- wb_stall is combinational, = (state==WAIT_LOAD). There is no other stall source.
- rf_wen/rf_wa/rf_wd are registered. rf_wen is high for exactly one cycle per write. rf_wa/rf_wd hold their last values when rf_wen=0.
- IDLE, mem_valid=1, mem_is_load=0:
  - Next cycle: rf_wen = mem_regwrite && (mem_rd!=0), rf_wa=mem_rd, rf_wd=mem_alu_result.
  - retire_cnt+1.
  - Stay IDLE. Back-to-back accepts every cycle are allowed.
- IDLE, mem_valid=1, mem_is_load=1:
  - Capture rd (forced to 0 if mem_regwrite=0), funct3 and addr_lo.
  - load_busy_rd = captured rd. Go to WAIT_LOAD. No write this cycle.
- IDLE, mem_valid=0: no write. dbus_rvalid is ignored.
- WAIT_LOAD:
  - mem_* inputs are ignored.
  - On dbus_rvalid: the formatted data is written next cycle (suppressed if captured rd==0); retire_cnt+1; load_busy_rd=0; go to IDLE.
  - wb_stall drops the cycle after the rvalid cycle. The first new accept follows, so a load retires no sooner than 2 cycles after issue.
- Load formatting, byte lane = dbus_rdata[8*addr_lo +: 8], half = dbus_rdata[16*addr_lo[1] +: 16]:
  - 000 LB: sign-extended byte
  - 001 LH: sign-extended half
  - 010 LW: full word
  - 100 LBU: zero-extended byte
  - 101 LHU: zero-extended half
  - 011/110/111: treated as LW
  - Misaligned LH/LW: addr_lo[0] is ignored for LH, and addr_lo is ignored for LW.
- dbus_rvalid in the same cycle as load issue (IDLE): ignored. Data must arrive at least 1 cycle after issue.
- retire_cnt wraps 0xFFFFFFFF -> 0. Retirements with no write (rd==0, regwrite=0) still count.

Optional Feature:
- WB_LOAD_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to WAIT_LOAD and increments each WAIT_LOAD cycle without dbus_rvalid.
  - When it reaches TIMEOUT_CYCLES: write 0 to captured rd (if nonzero) next cycle, pulse load_fault for 1 cycle, do not increment retire_cnt, go to IDLE.
  - dbus_rvalid in the same cycle as the timeout wins; it is a normal completion.
- Undefined: no counter. WAIT_LOAD holds indefinitely. load_fault is tied 0.

Test Plan:
- ALU write: mem_valid=1, regwrite=1, rd=5, result=0xDEADBEEF -> next cycle rf_wen=1, rf_wa=5, rf_wd=0xDEADBEEF; retire_cnt=1.
- rd=0 suppression: ALU op with rd=0 -> rf_wen stays 0; retire_cnt increments.
- LB sign-extend: load rd=7, funct3=000, addr_lo=2, rvalid 3 cycles later with rdata=0x12AB3456 -> wb_stall high 3 cycles; then rf_wd=0xFFFFFFAB, rf_wa=7; load_busy_rd 7 then 0.
- LHU/LW: funct3=101, addr_lo=2, rdata=0x8001FFFF -> rf_wd=0x00008001. funct3=010 -> rf_wd=0x8001FFFF.
- Reset mid-load: issue load rd=9, assert reset, release, then pulse rvalid -> no write; wb_stall=0; outputs and retire_cnt=0.
- Timeout (WB_LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=4): load rd=3, no rvalid -> after 4 WAIT cycles rf_wen=1, rf_wd=0, load_fault pulses once, retire_cnt unchanged, state IDLE.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback stage: retires ALU results, waits on one outstanding data-bus load, formats it, drives the RF write port.
// Optional load timeout enabled by defining WB_LOAD_TIMEOUT_EN.
module writeback_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_regwrite,
    input  logic        mem_is_load,
    input  logic [4:0]  mem_rd,
    input  logic [2:0]  mem_funct3,
    input  logic [1:0]  mem_addr_lo,
    input  logic [31:0] mem_alu_result,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    output logic        rf_wen,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        wb_stall,
    output logic [4:0]  load_busy_rd,
    output logic        load_fault,
    output logic [31:0] retire_cnt
);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data;
    logic        accept_alu, issue_load, load_done, load_abort;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    assign wb_stall     = (state == WAIT_LOAD);
    assign load_busy_rd = ld_rd;

    always_comb begin
        byte_lane = dbus_rdata[7:0];
        case (ld_addr)
            2'd0:    byte_lane = dbus_rdata[7:0];
            2'd1:    byte_lane = dbus_rdata[15:8];
            2'd2:    byte_lane = dbus_rdata[23:16];
            default: byte_lane = dbus_rdata[31:24];
        endcase
        half_lane = ld_addr[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    end

    // Unsupported funct3 encodings fall through to a full-word load.
    always_comb begin
        load_data = dbus_rdata;
        case (ld_funct3)
            3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
            3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
            3'b100:  load_data = {24'd0, byte_lane};
            3'b101:  load_data = {16'd0, half_lane};
            default: load_data = dbus_rdata;
        endcase
    end

`ifdef WB_LOAD_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        fault;

    // rvalid on the expiry cycle takes priority and completes normally.
    assign load_abort = (state == WAIT_LOAD) && !dbus_rvalid
                        && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign load_fault = fault;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            fault    <= 1'b0;
        end else begin
            fault <= load_abort;
            if (issue_load)
                wait_cnt <= '0;
            else if (state == WAIT_LOAD && !dbus_rvalid)
                wait_cnt <= wait_cnt + 16'd1;
        end
    end
`else
    assign load_abort = 1'b0;
    assign load_fault = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept_alu = 1'b0;
        issue_load = 1'b0;
        load_done  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_valid) begin
                    if (mem_is_load) begin
                        issue_load = 1'b1;
                        state_next = WAIT_LOAD;
                    end else begin
                        accept_alu = 1'b1;
                    end
                end
            end
            WAIT_LOAD: begin
                if (dbus_rvalid) begin
                    load_done  = 1'b1;
                    state_next = IDLE;
                end else if (load_abort) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rf_wen     <= 1'b0;
            rf_wa      <= '0;
            rf_wd      <= '0;
            retire_cnt <= '0;
            ld_rd      <= '0;
            ld_funct3  <= '0;
            ld_addr    <= '0;
        end else begin
            rf_wen <= 1'b0;
            if (accept_alu) begin
                retire_cnt <= retire_cnt + 32'd1;
                if (mem_regwrite && mem_rd != 5'd0) begin
                    rf_wen <= 1'b1;
                    rf_wa  <= mem_rd;
                    rf_wd  <= mem_alu_result;
                end
            end
            if (issue_load) begin
                ld_rd     <= mem_regwrite ? mem_rd : 5'd0;
                ld_funct3 <= mem_funct3;
                ld_addr   <= mem_addr_lo;
            end
            if (load_done) begin
                retire_cnt <= retire_cnt + 32'd1;
                ld_rd      <= '0;
                if (ld_rd != 5'd0) begin
                    rf_wen <= 1'b1;
                    rf_wa  <= ld_rd;
                    rf_wd  <= load_data;
                end
            end else if (load_abort) begin
                ld_rd <= '0;
                if (ld_rd != 5'd0) begin
                    rf_wen <= 1'b1;
                    rf_wa  <= ld_rd;
                    rf_wd  <= '0;
                end
            end
        end
    end

endmodule
